// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 constants, status codes and write-back FSM state type
// Contents: DATA_W, icode constants IHALT..IPOPQ, register ids RRSP/RNONE,
// status codes AOK/HLT/ADR/INS, wb_state_t and the status priority function.
package y86_pkg;
    localparam int DATA_W = 64;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RRSP    = 4'h4;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] AOK     = 3'd1;
    localparam logic [2:0] HLT     = 3'd2;
    localparam logic [2:0] ADR     = 3'd3;
    localparam logic [2:0] INS     = 3'd4;
    typedef enum logic {RUN, HALTED} wb_state_t;
    function automatic logic [2:0] wb_status(input logic pc_invalid, input logic ins_invalid,
                                             input logic [3:0] icode, input logic mem_addr_err);
        return pc_invalid ? ADR : ins_invalid ? INS : icode == IHALT ? HLT : mem_addr_err ? ADR : AOK;
    endfunction
endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: program register file, two combinational reads, two writes (M port wins)
// Ports: clk, rst_n (async, active-low); we, dst_e/val_e, dst_m/val_m write ports;
// src_a/src_b -> val_a/val_b read ports, RNONE reads as 0.
// WB_BYPASS_EN: reads forward the write data committing on the coming edge.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [3:0]        dst_e,
    input  logic [3:0]        dst_m,
    input  logic [DATA_W-1:0] val_e,
    input  logic [DATA_W-1:0] val_m,
    input  logic [3:0]        src_a,
    input  logic [3:0]        src_b,
    output logic [DATA_W-1:0] val_a,
    output logic [DATA_W-1:0] val_b
);
    logic [DATA_W-1:0] regs [NREGS];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we) begin
            if (dst_e != RNONE) regs[dst_e] <= val_e;
            // Later assignment wins, so popq %rsp keeps the loaded value.
            if (dst_m != RNONE) regs[dst_m] <= val_m;
        end
    end
`ifdef WB_BYPASS_EN
    assign val_a = src_a == RNONE ? '0 : we && src_a == dst_m ? val_m : we && src_a == dst_e ? val_e : regs[src_a];
    assign val_b = src_b == RNONE ? '0 : we && src_b == dst_m ? val_m : we && src_b == dst_e ? val_e : regs[src_b];
`else
    assign val_a = src_a == RNONE ? '0 : regs[src_a];
    assign val_b = src_b == RNONE ? '0 : regs[src_b];
`endif
endmodule

// File: rtl/y86_writeback.sv
// y86_writeback: Y86-64 SEQ write-back/commit stage with sticky halt
// Ports: clk, rst_n (async, active-low); wb_valid, icode, ifun, cnd, r_a, r_b,
// val_e, val_m, pc_invalid, ins_invalid, mem_addr_err from memory stage;
// src_a/src_b -> val_a_rd/val_b_rd decode reads; stat, halted, retired status.
// Optional macro WB_BYPASS_EN: same-cycle forwarding on the read ports.
module y86_writeback
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int NREGS  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic              cnd,
    input  logic [3:0]        r_a,
    input  logic [3:0]        r_b,
    input  logic [DATA_W-1:0] val_e,
    input  logic [DATA_W-1:0] val_m,
    input  logic              pc_invalid,
    input  logic              ins_invalid,
    input  logic              mem_addr_err,
    input  logic [3:0]        src_a,
    input  logic [3:0]        src_b,
    output logic [DATA_W-1:0] val_a_rd,
    output logic [DATA_W-1:0] val_b_rd,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [63:0]       retired
);
    wb_state_t  state, state_nx;
    logic [2:0] st;
    logic [3:0] dst_e, dst_m;
    logic       run, we, unused_ifun;
    assign unused_ifun = ^ifun;
    assign st = wb_status(pc_invalid, ins_invalid, icode, mem_addr_err);
    assign run = state == RUN;
    assign we = wb_valid && run && st == AOK;
    assign halted = state == HALTED;
    always_comb begin
        dst_e = (icode == IRRMOVQ && cnd) || icode == IIRMOVQ || icode == IOPQ ? r_b :
                icode inside {ICALL, IRET, IPUSHQ, IPOPQ} ? RRSP : RNONE;
        dst_m = icode inside {IMRMOVQ, IPOPQ} ? r_a : RNONE;
        state_nx = run && wb_valid && st != AOK ? HALTED : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat    <= AOK;
            retired <= '0;
        end else if (run && wb_valid) begin
            stat <= st;
            if ((st == AOK || st == HLT) && ~&retired) retired <= retired + 64'd1;
        end
    end
    y86_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .dst_e (dst_e),
        .dst_m (dst_m),
        .val_e (val_e),
        .val_m (val_m),
        .src_a (src_a),
        .src_b (src_b),
        .val_a (val_a_rd),
        .val_b (val_b_rd)
    );
endmodule

// File: tb/tb_y86_writeback.sv
// tb_y86_writeback: directed and randomized check of y86_writeback against a behavioural model
module tb_y86_writeback;
    import y86_pkg::*;
    logic        clk = 0, rst_n = 1, wb_valid = 0, cnd = 0;
    logic        pc_invalid = 0, ins_invalid = 0, mem_addr_err = 0;
    logic [3:0]  icode = 0, ifun = 0, r_a = 15, r_b = 15, src_a = 15, src_b = 15;
    logic [63:0] val_e = 0, val_m = 0, val_a_rd, val_b_rd, retired;
    logic [2:0]  stat;
    logic        halted;
    int          tests = 0, fails = 0;
    logic [63:0] m_regs [15];
    logic [63:0] m_next [15];
    logic [63:0] m_ret;
    logic [2:0]  m_stat, m_st;
    logic        m_halt;

    y86_writeback dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode), .ifun(ifun), .cnd(cnd),
        .r_a(r_a), .r_b(r_b), .val_e(val_e), .val_m(val_m), .pc_invalid(pc_invalid),
        .ins_invalid(ins_invalid), .mem_addr_err(mem_addr_err), .src_a(src_a), .src_b(src_b),
        .val_a_rd(val_a_rd), .val_b_rd(val_b_rd), .stat(stat), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_stat = 3'd1;
        m_halt = 0;
        m_ret = '0;
    endtask

    // Architectural effect of the instruction currently on the inputs.
    task automatic m_plan();
        logic [3:0] de, dm;
        m_st = pc_invalid ? 3'd3 : ins_invalid ? 3'd4 : icode == 4'd0 ? 3'd2 : mem_addr_err ? 3'd3 : 3'd1;
        case (icode)
            4'd2: de = cnd ? r_b : 4'd15;
            4'd3, 4'd6: de = r_b;
            4'd8, 4'd9, 4'd10, 4'd11: de = 4'd4;
            default: de = 4'd15;
        endcase
        dm = (icode == 4'd5 || icode == 4'd11) ? r_a : 4'd15;
        m_next = m_regs;
        if (wb_valid && !m_halt && m_st == 3'd1) begin
            if (de != 4'd15) m_next[de] = val_e;
            if (dm != 4'd15) m_next[dm] = val_m;
        end
    endtask

    function automatic logic [63:0] m_rd(input logic [3:0] s);
`ifdef WB_BYPASS_EN
        return s == 4'd15 ? 64'd0 : m_next[s];
`else
        return s == 4'd15 ? 64'd0 : m_regs[s];
`endif
    endfunction

    // Entered at a falling edge with inputs set; leaves at the next falling edge.
    task automatic tick();
        m_plan();
        #1;
        check("rd_a", val_a_rd, m_rd(src_a));
        check("rd_b", val_b_rd, m_rd(src_b));
        @(posedge clk);
        if (wb_valid && !m_halt) begin
            m_stat = m_st;
            if (m_st == 3'd1 || m_st == 3'd2) m_ret = m_ret + 1;
            if (m_st != 3'd1) m_halt = 1;
        end
        m_regs = m_next;
        #1;
        check("stat", {61'd0, stat}, {61'd0, m_stat});
        check("halted", {63'd0, halted}, {63'd0, m_halt});
        check("retired", retired, m_ret);
        @(negedge clk);
    endtask

    task automatic instr(input logic [3:0] ic, input logic c, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] ve, input logic [63:0] vm, input logic [2:0] err,
                         input logic [3:0] sa, input logic [3:0] sb);
        wb_valid = 1; icode = ic; cnd = c; r_a = ra; r_b = rb; val_e = ve; val_m = vm;
        {pc_invalid, ins_invalid, mem_addr_err} = err;
        src_a = sa; src_b = sb;
        tick();
    endtask

    task automatic idle(input logic [3:0] sa, input logic [3:0] sb);
        wb_valid = 0; {pc_invalid, ins_invalid, mem_addr_err} = 3'b000;
        src_a = sa; src_b = sb;
        tick();
    endtask

    // Asserts reset mid-cycle over whatever inputs are present; pending writes must be dropped.
    task automatic do_reset();
        #2 rst_n = 0;
        model_reset();
        #1;
        check("rst_stat", {61'd0, stat}, 64'd1);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_retired", retired, 64'd0);
        for (int i = 0; i < 15; i++) begin
            src_a = 4'(i);
            #1 check("rst_reg", val_a_rd, 64'd0);
        end
        @(posedge clk);
        @(negedge clk);
        wb_valid = 0;
        rst_n = 1;
    endtask

    initial begin
        do_reset();
        instr(4'd3, 0, 4'd15, 4'd2, 64'h55, 64'h0, 3'b000, 4'd2, 4'd15);
        idle(4'd2, 4'd15);
        check("irmov_rd", val_a_rd, 64'h55);
        check("irmov_ret", retired, 64'd1);
        instr(4'd11, 0, 4'd4, 4'd15, 64'h108, 64'h77, 3'b000, 4'd4, 4'd2);
        idle(4'd4, 4'd15);
        check("popq_rsp", val_a_rd, 64'h77);
        instr(4'd2, 0, 4'd1, 4'd3, 64'hAA, 64'h0, 3'b000, 4'd3, 4'd15);
        idle(4'd3, 4'd15);
        check("cmov_nt", val_a_rd, 64'h0);
        instr(4'd2, 1, 4'd1, 4'd3, 64'h9, 64'h0, 3'b000, 4'd3, 4'd15);
        idle(4'd3, 4'd15);
        check("cmov_t", val_a_rd, 64'h9);
        instr(4'd5, 0, 4'd6, 4'd1, 64'h10, 64'h66, 3'b001, 4'd6, 4'd15);
        check("adr_stat", {61'd0, stat}, 64'd3);
        check("adr_halted", {63'd0, halted}, 64'd1);
        instr(4'd3, 0, 4'd15, 4'd7, 64'h99, 64'h0, 3'b000, 4'd7, 4'd6);
        idle(4'd7, 4'd6);
        check("halt_blk_rd", val_a_rd, 64'h0);
        check("halt_blk_ret", retired, 64'd4);
        check("halt_blk_stat", {61'd0, stat}, 64'd3);
        wb_valid = 1; icode = 4'd3; r_b = 4'd5; val_e = 64'h1234;
        do_reset();
        idle(4'd5, 4'd2);
        check("rst_drop", val_a_rd, 64'h0);
        instr(4'd0, 0, 4'd15, 4'd15, 64'h0, 64'h0, 3'b000, 4'd15, 4'd15);
        check("hlt_stat", {61'd0, stat}, 64'd2);
        check("hlt_halted", {63'd0, halted}, 64'd1);
        check("hlt_ret", retired, 64'd1);
        do_reset();
        instr(4'd6, 0, 4'd1, 4'd2, 64'h5, 64'h0, 3'b110, 4'd2, 4'd15);
        check("pc_ins_stat", {61'd0, stat}, 64'd3);
        check("pc_ins_ret", retired, 64'd0);
        do_reset();
        instr(4'd3, 0, 4'd15, 4'd8, 64'hBEEF, 64'h0, 3'b000, 4'd8, 4'd8);
        for (int ep = 0; ep < 6; ep++) begin
            for (int n = 0; n < 40; n++) begin
                wb_valid = $urandom_range(0, 4) != 0;
                icode = $urandom_range(0, 29) == 0 ? 4'd0 : 4'($urandom_range(1, 13));
                ifun = 4'($urandom);
                cnd = 1'($urandom);
                r_a = 4'($urandom);
                r_b = 4'($urandom);
                val_e = {$urandom, $urandom};
                val_m = {$urandom, $urandom};
                pc_invalid = $urandom_range(0, 59) == 0;
                ins_invalid = $urandom_range(0, 59) == 0;
                mem_addr_err = $urandom_range(0, 39) == 0;
                src_a = $urandom_range(0, 2) == 0 ? r_b : 4'($urandom);
                src_b = $urandom_range(0, 2) == 0 ? r_a : 4'($urandom);
                tick();
            end
            do_reset();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
